rvsteel_dma: RTL and testbench

RVSTEEL_DMA -- requirements
Module: rvsteel_dma

---
 rtl/rvsteel_dma_pkg.sv | 22 ++
 rtl/rvsteel_dma.sv | 148 ++++++++++++++
 tb/tb_rvsteel_dma.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvsteel_dma_pkg.sv
// Shared definitions for the rvsteel DMA engine: register map, control/status
// bit positions and FSM state encoding.
package rvsteel_dma_pkg;

  localparam logic [4:0] REG_SRC    = 5'h00;
  localparam logic [4:0] REG_DST    = 5'h04;
  localparam logic [4:0] REG_LEN    = 5'h08;
  localparam logic [4:0] REG_CTRL   = 5'h0C;
  localparam logic [4:0] REG_STATUS = 5'h10;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IE     = 1;
  localparam int unsigned STATUS_BUSY = 0;
  localparam int unsigned STATUS_DONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

endpackage

// File: rtl/rvsteel_dma.sv
// Single-channel memory-to-memory word copy engine with a small register-mapped
// config port and a one-outstanding-request initiator port.
module rvsteel_dma
  import rvsteel_dma_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,

  input  logic [4:0]  rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,

  output logic [31:0] m_rw_address,
  input  logic [31:0] m_read_data,
  output logic        m_read_request,
  input  logic        m_read_response,
  output logic [31:0] m_write_data,
  output logic [3:0]  m_write_strobe,
  output logic        m_write_request,
  input  logic        m_write_response,

  output logic        irq
);

  state_t state, state_next;

  logic [29:0]          src_q, dst_q, work_src, work_dst;
  logic [LEN_WIDTH-1:0] len_q, work_cnt;
  logic [31:0]          data_q;
  logic                 ie, done;

  logic busy, cfg_wr, start, rd_done, wr_done, last_word;
  logic done_set, done_clr;

  assign busy      = (state != IDLE);
  assign cfg_wr    = write_request && (rw_address[1:0] == 2'b00) && (write_strobe == 4'hF);
  assign start     = cfg_wr && (rw_address == REG_CTRL) && write_data[CTRL_START] && !busy;
  assign rd_done   = (state == RD) && m_read_response;
  assign wr_done   = (state == WR) && m_write_response;
  assign last_word = wr_done && (work_cnt == LEN_WIDTH'(1));

  // A set in the same cycle as a clear (START or W1C) leaves DONE high.
  assign done_set = (start && (len_q == '0)) || last_word;
  assign done_clr = start ||
                    (cfg_wr && (rw_address == REG_STATUS) && write_data[STATUS_DONE]);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && (len_q != '0)) state_next = RD;
      RD:   if (m_read_response)        state_next = WR;
      WR:   if (m_write_response)       state_next = last_word ? IDLE : RD;
      default:                          state_next = IDLE;
    endcase
  end

  always_comb begin
    m_rw_address    = '0;
    m_read_request  = 1'b0;
    m_write_data    = '0;
    m_write_strobe  = '0;
    m_write_request = 1'b0;
    case (state)
      RD: begin
        m_rw_address   = {work_src, 2'b00};
        m_read_request = 1'b1;
      end
      WR: begin
        m_rw_address    = {work_dst, 2'b00};
        m_write_data    = data_q;
        m_write_strobe  = 4'hF;
        m_write_request = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      src_q          <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      ie             <= 1'b0;
      done           <= 1'b0;
      work_src       <= '0;
      work_dst       <= '0;
      work_cnt       <= '0;
      data_q         <= '0;
      read_data      <= '0;
      read_response  <= 1'b0;
      write_response <= 1'b0;
      irq            <= 1'b0;
    end else begin
      read_response  <= read_request;
      write_response <= write_request;
      irq            <= done && ie;

      if (cfg_wr && !busy) begin
        if (rw_address == REG_SRC) src_q <= write_data[31:2];
        if (rw_address == REG_DST) dst_q <= write_data[31:2];
        if (rw_address == REG_LEN) len_q <= write_data[LEN_WIDTH-1:0];
      end
      if (cfg_wr && (rw_address == REG_CTRL)) ie <= write_data[CTRL_IE];

      if (done_set)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;

      if (start) begin
        work_src <= src_q;
        work_dst <= dst_q;
        work_cnt <= len_q;
      end

      if (rd_done) data_q <= m_read_data;

      // Word addresses wrap naturally at 2^30, i.e. byte addresses at 2^32.
      if (wr_done) begin
        work_src <= work_src + 30'd1;
        work_dst <= work_dst + 30'd1;
        work_cnt <= work_cnt - LEN_WIDTH'(1);
      end

      if (read_request && (rw_address[1:0] == 2'b00)) begin
        case (rw_address)
          REG_SRC:    read_data <= {src_q, 2'b00};
          REG_DST:    read_data <= {dst_q, 2'b00};
          REG_LEN:    read_data <= 32'(len_q);
          REG_CTRL:   read_data <= {30'd0, ie, 1'b0};
          REG_STATUS: read_data <= {30'd0, done, busy};
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rvsteel_dma.sv
// Directed self-checking bench for rvsteel_dma with a latency-programmable
// memory responder on the initiator port.
module tb_rvsteel_dma;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rw_address;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;
  logic [31:0] m_rw_address;
  logic [31:0] m_read_data;
  logic        m_read_request;
  logic        m_read_response;
  logic [31:0] m_write_data;
  logic [3:0]  m_write_strobe;
  logic        m_write_request;
  logic        m_write_response;
  logic        irq;

  always #5 clock = ~clock;

  rvsteel_dma #(.LEN_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .rw_address(rw_address), .read_data(read_data),
    .read_request(read_request), .read_response(read_response),
    .write_data(write_data), .write_strobe(write_strobe),
    .write_request(write_request), .write_response(write_response),
    .m_rw_address(m_rw_address), .m_read_data(m_read_data),
    .m_read_request(m_read_request), .m_read_response(m_read_response),
    .m_write_data(m_write_data), .m_write_strobe(m_write_strobe),
    .m_write_request(m_write_request), .m_write_response(m_write_response),
    .irq(irq)
  );

  // Memory word i holds 0xA5A50000 + 17*i, indexed by address bits [9:2].
  logic [31:0] mem [256];
  int unsigned lat;
  int unsigned rcnt, wcnt;
  logic        late_rresp;

  assign m_read_data      = mem[m_rw_address[9:2]];
  assign m_read_response  = (m_read_request && (rcnt == lat)) || late_rresp;
  assign m_write_response = m_write_request && (wcnt == lat);

  logic [31:0] rd_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_strb_q[$];
  int unsigned rd_dur_q[$];
  int unsigned wr_dur_q[$];
  bit          ev_q[$];
  int unsigned overlap;

  always @(posedge clock) begin
    rcnt <= (m_read_request && !m_read_response) ? rcnt + 1 : 0;
    wcnt <= (m_write_request && !m_write_response) ? wcnt + 1 : 0;
    if (m_read_request && m_write_request) overlap <= overlap + 1;
    if (!reset && m_read_request && m_read_response) begin
      rd_addr_q.push_back(m_rw_address);
      rd_dur_q.push_back(rcnt + 1);
      ev_q.push_back(1'b0);
    end
    if (!reset && m_write_request && m_write_response) begin
      wr_addr_q.push_back(m_rw_address);
      wr_data_q.push_back(m_write_data);
      wr_strb_q.push_back(m_write_strobe);
      wr_dur_q.push_back(wcnt + 1);
      ev_q.push_back(1'b1);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clock);
    rw_address = a; write_data = d; write_strobe = s; write_request = 1'b1;
    @(negedge clock);
    write_request = 1'b0; write_strobe = 4'h0;
  endtask

  task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clock);
    rw_address = a; read_request = 1'b1;
    @(negedge clock);
    read_request = 1'b0;
    d = read_data;
  endtask

  task automatic wait_idle(input int unsigned max_polls, output logic ok);
    logic [31:0] st;
    ok = 1'b0;
    for (int unsigned i = 0; i < max_polls; i++) begin
      cfg_read(5'h10, st);
      if (st[0] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    wr_strb_q.delete(); rd_dur_q.delete(); wr_dur_q.delete(); ev_q.delete();
  endtask

  logic [31:0] d;
  logic        ok;
  logic [5:0]  pattern;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A50000 + 32'(i) * 32'd17;
    reset = 1'b1; lat = 0; late_rresp = 1'b0; overlap = 0;
    rw_address = '0; write_data = '0; write_strobe = '0;
    read_request = 1'b0; write_request = 1'b0;
    rcnt = 0; wcnt = 0;
    repeat (3) @(negedge clock);

    check("rst_read_data", read_data, 32'h0);
    check("rst_read_resp", {31'd0, read_response}, 32'h0);
    check("rst_write_resp", {31'd0, write_response}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_m_req", {30'd0, m_read_request, m_write_request}, 32'h0);
    check("rst_m_addr", m_rw_address, 32'h0);
    check("rst_m_wdata", m_write_data, 32'h0);
    check("rst_m_strb", {28'd0, m_write_strobe}, 32'h0);
    reset = 1'b0;
    cfg_read(5'h10, d);
    check("rst_status", d, 32'h0);

    // Basic 3-word copy, zero-latency responder; SRC low bits are dropped.
    clear_logs();
    cfg_write(5'h00, 32'h0000_0103, 4'hF);
    cfg_read(5'h00, d);
    check("src_low_bits", d, 32'h0000_0100);
    cfg_write(5'h04, 32'h0000_0200, 4'hF);
    cfg_write(5'h08, 32'd3, 4'hF);
    cfg_write(5'h0C, 32'h1, 4'hF);
    wait_idle(100, ok);
    check("t1_timeout", {31'd0, ok}, 32'h1);
    check("t1_nrd", rd_addr_q.size(), 32'd3);
    check("t1_nwr", wr_addr_q.size(), 32'd3);
    if (rd_addr_q.size() == 3 && wr_addr_q.size() == 3) begin
      check("t1_rd0", rd_addr_q[0], 32'h100);
      check("t1_rd1", rd_addr_q[1], 32'h104);
      check("t1_rd2", rd_addr_q[2], 32'h108);
      check("t1_wr0", wr_addr_q[0], 32'h200);
      check("t1_wr1", wr_addr_q[1], 32'h204);
      check("t1_wr2", wr_addr_q[2], 32'h208);
      check("t1_wd0", wr_data_q[0], 32'hA5A50440);
      check("t1_wd1", wr_data_q[1], 32'hA5A50451);
      check("t1_wd2", wr_data_q[2], 32'hA5A50462);
    end
    pattern = '1;
    if (ev_q.size() == 6) for (int i = 0; i < 6; i++) pattern[5-i] = ev_q[i];
    check("t1_alternate", {26'd0, pattern}, 32'b010101);
    cfg_read(5'h10, d);
    check("t1_status", d, 32'h2);
    check("t1_irq_masked", {31'd0, irq}, 32'h0);

    // 5-cycle latency: each request held exactly 6 cycles, never overlapping.
    clear_logs();
    lat = 5;
    cfg_write(5'h00, 32'h0000_0140, 4'hF);
    cfg_write(5'h04, 32'h0000_0240, 4'hF);
    cfg_write(5'h08, 32'd2, 4'hF);
    cfg_write(5'h0C, 32'h1, 4'hF);
    wait_idle(100, ok);
    check("t2_timeout", {31'd0, ok}, 32'h1);
    check("t2_nwr", wr_addr_q.size(), 32'd2);
    if (rd_dur_q.size() == 2 && wr_dur_q.size() == 2) begin
      check("t2_rdur0", rd_dur_q[0], 32'd6);
      check("t2_rdur1", rd_dur_q[1], 32'd6);
      check("t2_wdur0", wr_dur_q[0], 32'd6);
      check("t2_wdur1", wr_dur_q[1], 32'd6);
      check("t2_wr1", wr_addr_q[1], 32'h244);
      check("t2_wd0", wr_data_q[0], 32'hA5A50550);
      check("t2_wd1", wr_data_q[1], 32'hA5A50561);
      check("t2_strb", {28'd0, wr_strb_q[0]}, 32'hF);
    end
    check("t2_overlap", overlap, 32'd0);

    // LEN=0 with IE: DONE without traffic, irq follows, W1C clears it.
    clear_logs();
    lat = 0;
    cfg_write(5'h08, 32'd0, 4'hF);
    cfg_write(5'h0C, 32'h3, 4'hF);
    cfg_read(5'h10, d);
    check("t3_status", d, 32'h2);
    check("t3_irq_set", {31'd0, irq}, 32'h1);
    check("t3_no_traffic", rd_addr_q.size() + wr_addr_q.size(), 32'd0);
    cfg_read(5'h0C, d);
    check("t3_ctrl", d, 32'h2);
    cfg_write(5'h10, 32'h2, 4'hF);
    @(negedge clock);
    check("t3_irq_clr", {31'd0, irq}, 32'h0);
    cfg_read(5'h10, d);
    check("t3_status_clr", d, 32'h0);

    // Partial-strobe write ignored; unaligned and unmapped reads keep read_data.
    cfg_write(5'h00, 32'hDEAD_0000, 4'h3);
    cfg_read(5'h00, d);
    check("strobe_ignored", d, 32'h0000_0140);
    cfg_read(5'h01, d);
    check("unaligned_read", d, 32'h0000_0140);
    cfg_read(5'h14, d);
    check("unmapped_read", d, 32'h0000_0140);

    // Source address wraps past 0xFFFFFFFC.
    clear_logs();
    cfg_write(5'h0C, 32'h0, 4'hF);
    cfg_write(5'h00, 32'hFFFF_FFFC, 4'hF);
    cfg_write(5'h04, 32'h0000_0300, 4'hF);
    cfg_write(5'h08, 32'd2, 4'hF);
    cfg_write(5'h0C, 32'h1, 4'hF);
    wait_idle(100, ok);
    check("t4_timeout", {31'd0, ok}, 32'h1);
    check("t4_nrd", rd_addr_q.size(), 32'd2);
    if (rd_addr_q.size() == 2 && wr_data_q.size() == 2) begin
      check("t4_rd0", rd_addr_q[0], 32'hFFFF_FFFC);
      check("t4_rd1", rd_addr_q[1], 32'h0000_0000);
      check("t4_wd0", wr_data_q[0], 32'hA5A510EF);
      check("t4_wd1", wr_data_q[1], 32'hA5A50000);
    end

    // START / DST / LEN writes while busy are ignored.
    clear_logs();
    lat = 5;
    cfg_write(5'h00, 32'h0000_0180, 4'hF);
    cfg_write(5'h04, 32'h0000_0280, 4'hF);
    cfg_write(5'h08, 32'd2, 4'hF);
    cfg_write(5'h0C, 32'h1, 4'hF);
    cfg_write(5'h04, 32'h0000_0900, 4'hF);
    cfg_write(5'h0C, 32'h1, 4'hF);
    cfg_write(5'h08, 32'd7, 4'hF);
    cfg_read(5'h10, d);
    check("t5_busy", d, 32'h1);
    wait_idle(100, ok);
    check("t5_timeout", {31'd0, ok}, 32'h1);
    cfg_read(5'h04, d);
    check("t5_dst_kept", d, 32'h0000_0280);
    cfg_read(5'h08, d);
    check("t5_len_kept", d, 32'd2);
    check("t5_nwr", wr_addr_q.size(), 32'd2);
    check("t5_nrd", rd_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("t5_wr0", wr_addr_q[0], 32'h280);
      check("t5_wr1", wr_addr_q[1], 32'h284);
      check("t5_wd1", wr_data_q[1], 32'hA5A50671);
    end

    // Reset during RD drops the request; a late response triggers nothing.
    clear_logs();
    lat = 50;
    cfg_write(5'h00, 32'h0000_01C0, 4'hF);
    cfg_write(5'h04, 32'h0000_02C0, 4'hF);
    cfg_write(5'h08, 32'd1, 4'hF);
    cfg_write(5'h0C, 32'h1, 4'hF);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_read_request) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("t6_rd_seen", {31'd0, ok}, 32'h1);
    reset = 1'b1;
    @(negedge clock);
    check("t6_rd_dropped", {31'd0, m_read_request}, 32'h0);
    check("t6_wr_idle", {31'd0, m_write_request}, 32'h0);
    reset = 1'b0;
    late_rresp = 1'b1;
    @(negedge clock);
    late_rresp = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_no_write", {31'd0, m_write_request}, 32'h0);
    check("t6_nwr", wr_addr_q.size(), 32'd0);
    cfg_read(5'h10, d);
    check("t6_status", d, 32'h0);
    check("overlap_total", overlap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
